sat_accum_stream: RTL
=====================

// Module: sat_accum_stream
// PURPOSE
//  Streaming signed accumulator with saturation; sits directly downstream of the
//  signed saturating adder stage and consumes its W-bit two's-complement results.
//  Sums each packet (beats up to and including up_last) with per-beat clamping.
//  Emits one result beat per packet over valid/ready with sum, sticky sat flag and beat count.
// PARAMETERS
//  W      4   sample/accumulator width, signed two's complement (W >= 2)
//  CNT_W  8   beat-counter width; count saturates at 2**CNT_W-1
// PORTS
//  clk          in   1      clock, all state on rising edge
//  rst_n        in   1      asynchronous active-low reset
//  up_valid     in   1      upstream sample valid
//  up_ready     out  1      block accepts sample this cycle
//  up_data      in   W      signed sample
//  up_last      in   1      sample is last of packet
//  down_valid   out  1      result valid
//  down_ready   in   1      downstream accepts result
//  down_data    out  W      saturated packet sum
//  down_sat     out  1      1 if any beat of packet clamped
//  down_count   out  CNT_W  beats in packet
// BEHAVIOUR
//  - Reset (async assert, sync-deasserted externally): acc=0, cnt=0, sat=0, state IDLE,
//    down_valid=0, down_data=0, down_sat=0, down_count=0.
//  - up_ready = !down_valid || down_ready (input stalls only while result unconsumed).
//  - Accept = up_valid && up_ready. Per accepted beat: nxt = sat_add(base, up_data),
//    base = 0 in IDLE, acc in ACCUM; sat |= clamp; cnt = min(cnt+1, 2**CNT_W-1).
//  - Saturation: both operands >=0 and raw sign bit 1 -> 2**(W-1)-1; both <0 and raw
//    sign bit 0 -> -2**(W-1); otherwise wrapped sum. Once clamped, later beats continue
//    from clamped value (e.g. +7 then -1 -> +6).
//  - FSM: IDLE --accept & !last--> ACCUM; ACCUM --accept & last--> IDLE; IDLE --accept
//    & last--> IDLE (single-beat packet). No accept: hold.
//  - On accepted last beat: down_data/down_sat/down_count loaded with final values,
//    down_valid=1 next cycle (latency 1 from last beat); acc/cnt/sat cleared same edge.
//  - Result held stable while down_valid && !down_ready. Clears when handshake occurs
//    unless a new last beat is accepted that same cycle (then reloaded, stays 1).
//  - Back-to-back single-beat packets sustain 1 result/cycle with down_ready=1.
//  - Reset mid-packet discards partial sum and any pending result; no output beat.
//  - up_data/up_last ignored when !up_valid; X on them must not corrupt state.
// CONFIGURATION
//  SAT_ACCUM_STATS_EN defined: adds outputs stat_pkts [15:0] and stat_sat_pkts [15:0],
//   incremented on each result handshake (the latter only if down_sat); both wrap at
//   2**16; reset to 0. Undefined: ports and counters absent, behaviour otherwise identical.
// STRUCTURE
//  - Package sat_arith_pkg: function sat_max(W), sat_min(W), state enum
//    acc_state_t {ST_IDLE, ST_ACCUM}; shared with the adder stage.
//  - Sub-module sat_add_w #(W): combinational a+b -> {sum, clamped}; instantiated once.
//  - Top: FSM/acc/count registers plus one output holding register (skid not needed).
// TESTING (W=4, CNT_W=8)
//  - Packet 2,3,1(last), down_ready=1 -> down_data=6, down_sat=0, down_count=3, 1 cycle after last.
//  - Packet 5,4,-3(last) -> 5+4 clamps to 7, then 4; down_data=4, down_sat=1, count=3.
//  - Packet -8,-1(last) -> down_data=-8 (4'b1000), down_sat=1; single beat 7(last) -> 7, sat=0.
//  - down_ready=0 for 5 cycles with result pending -> up_ready=0, down_* stable; then
//    release -> up_ready=1 same cycle, next packet accepted without loss.
//  - 300-beat packet of 0s -> down_count=255, down_data=0, down_sat=0.
//  - rst_n low mid-packet after 1,1 -> all outputs 0; next packet 3(last) -> down_data=3.

Source files
------------

// File: rtl/sat_arith_pkg.sv
// Shared saturating-arithmetic helpers and accumulator state encoding,
// used by both the adder stage and the streaming accumulator.
package sat_arith_pkg;

   typedef enum logic {ST_IDLE = 1'b0, ST_ACCUM = 1'b1} acc_state_t;

   function automatic int sat_max(input int w);
      return (1 << (w - 1)) - 1;
   endfunction

   function automatic int sat_min(input int w);
      return -(1 << (w - 1));
   endfunction

endpackage

// File: rtl/sat_add_w.sv
// Combinational signed W-bit add with clamping to the representable range;
// clamped flags that the raw sum overflowed.
module sat_add_w
   import sat_arith_pkg::*;
#(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] sum,
   output logic         clamped
);

   localparam logic [W-1:0] MAXV = W'(sat_max(W));
   localparam logic [W-1:0] MINV = W'(sat_min(W));

   logic [W-1:0] raw;
   logic         pos_ovf;
   logic         neg_ovf;

   assign raw     = a + b;
   assign pos_ovf = !a[W-1] && !b[W-1] &&  raw[W-1];
   assign neg_ovf =  a[W-1] &&  b[W-1] && !raw[W-1];
   assign clamped = pos_ovf || neg_ovf;
   assign sum     = pos_ovf ? MAXV : (neg_ovf ? MINV : raw);

endmodule

// File: rtl/sat_accum_stream.sv
// Streaming per-packet saturating accumulator with a single output holding register.
// Optional SAT_ACCUM_STATS_EN adds packet / saturated-packet handshake counters.
module sat_accum_stream
   import sat_arith_pkg::*;
#(
   parameter int W     = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             up_valid,
   output logic             up_ready,
   input  logic [W-1:0]     up_data,
   input  logic             up_last,
   output logic             down_valid,
   input  logic             down_ready,
   output logic [W-1:0]     down_data,
   output logic             down_sat,
   output logic [CNT_W-1:0] down_count
`ifdef SAT_ACCUM_STATS_EN
   ,
   output logic [15:0]      stat_pkts,
   output logic [15:0]      stat_sat_pkts
`endif
);

   acc_state_t       state, nstate;
   logic [W-1:0]     acc;
   logic [CNT_W-1:0] cnt;
   logic             sat;

   logic             accept;
   logic             hshake;
   logic [W-1:0]     base;
   logic [W-1:0]     nxt_acc;
   logic             clamp;
   logic [CNT_W-1:0] cnt_base;
   logic [CNT_W-1:0] nxt_cnt;
   logic             nxt_sat;

   assign up_ready = !down_valid || down_ready;
   assign accept   = up_valid && up_ready;
   assign hshake   = down_valid && down_ready;

   // IDLE starts a fresh packet, so the stored state is ignored rather than cleared again
   assign base     = (state == ST_IDLE) ? '0 : acc;
   assign cnt_base = (state == ST_IDLE) ? '0 : cnt;
   assign nxt_cnt  = (cnt_base == '1) ? cnt_base : cnt_base + 1'b1;
   assign nxt_sat  = ((state == ST_ACCUM) && sat) || clamp;

   sat_add_w #(.W(W)) u_add (
      .a       (base),
      .b       (up_data),
      .sum     (nxt_acc),
      .clamped (clamp)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= nstate;
   end

   always_comb begin
      nstate = state;
      if (accept) nstate = up_last ? ST_IDLE : ST_ACCUM;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
         cnt <= '0;
         sat <= 1'b0;
      end else if (accept) begin
         if (up_last) begin
            acc <= '0;
            cnt <= '0;
            sat <= 1'b0;
         end else begin
            acc <= nxt_acc;
            cnt <= nxt_cnt;
            sat <= nxt_sat;
         end
      end
   end

   // A last beat accepted on the handshake edge reloads, keeping valid high
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         down_valid <= 1'b0;
         down_data  <= '0;
         down_sat   <= 1'b0;
         down_count <= '0;
      end else if (accept && up_last) begin
         down_valid <= 1'b1;
         down_data  <= nxt_acc;
         down_sat   <= nxt_sat;
         down_count <= nxt_cnt;
      end else if (hshake) begin
         down_valid <= 1'b0;
      end
   end

`ifdef SAT_ACCUM_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_pkts     <= '0;
         stat_sat_pkts <= '0;
      end else if (hshake) begin
         stat_pkts <= stat_pkts + 16'd1;
         if (down_sat) stat_sat_pkts <= stat_sat_pkts + 16'd1;
      end
   end
`endif

endmodule
